seq_detect_scheduler: RTL

//  Shares one 3-byte sequence matcher (default pattern 0x26,0xF5,0x6E) between NREQ byte-stream requesters.

---
 rtl/seq_detect_scheduler_pkg.sv | 21 ++
 rtl/seq_detect_scheduler_if.sv | 23 ++
 rtl/seq_detect_scheduler_rr_arbiter.sv | 36 +++
 rtl/seq_detect_scheduler.sv | 132 +++++++++++++
 4 files changed

// File: rtl/seq_detect_scheduler_pkg.sv
// Shared types and constants for the sequence-detect scheduler.
// State encoding, default pattern bytes and id-width helper.
package seq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    W0,
    W1,
    W2
  } state_t;

  localparam logic [7:0] PAT0_DEF    = 8'h26;
  localparam logic [7:0] PAT1_DEF    = 8'hF5;
  localparam logic [7:0] PAT2_DEF    = 8'h6E;
  localparam int         TIMEOUT_DEF = 15;

  function automatic int idw(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// Byte-stream bundle between the requesters and the scheduler.
// Sources drive valid/data; the scheduler answers with ready.
interface seq_detect_scheduler_if #(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/seq_detect_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid index at or after ptr.
// Returns both a one-hot vector and the binary index of the winner.
module rr_arbiter
  import seq_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] pick,
  output logic [IDW-1:0]  idx
);

  // scan from ptr with wrap-around, keep the first hit
  always_comb begin : scan
    logic           found;
    logic [IDW-1:0] k;
    int             kk;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    kk    = 0;
    for (int i = 0; i < NREQ; i++) begin
      kk = (int'(ptr) + i) % NREQ;
      k  = IDW'(kk);
      if (!found && req[k]) begin
        found   = 1'b1;
        pick[k] = 1'b1;
        idx     = k;
      end
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// One shared 3-byte matcher time-sliced between NREQ byte streams.
// Grant held until hit, mismatch or idle timeout; counts hits.
module seq_detect_scheduler
  import seq_sched_pkg::*;
#(
  parameter int         NREQ    = 4,
  parameter logic [7:0] PAT0    = PAT0_DEF,
  parameter logic [7:0] PAT1    = PAT1_DEF,
  parameter logic [7:0] PAT2    = PAT2_DEF,
  parameter int         TIMEOUT = TIMEOUT_DEF,
  parameter int         IDW     = idw(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_detect_scheduler_if.slave  bus,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic                   hit,
  output logic [IDW-1:0]         hit_id,
  output logic [7:0]             hit_count
);

  state_t          state, state_n;
  logic [NREQ-1:0] grant_n;
  logic [IDW-1:0]  owner, owner_n;
  logic [IDW-1:0]  ptr, ptr_n;
  logic [7:0]      timer, timer_n;
  logic            hit_n;
  logic [IDW-1:0]  hit_id_n;
  logic [7:0]      cnt_n;
  logic [NREQ-1:0] pick;
  logic [IDW-1:0]  pick_idx;
  logic [7:0]      byte_in;
  logic            acc;
  logic            rel;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req  (bus.req_valid),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  assign bus.req_ready = grant;
  assign busy          = (state != IDLE);
  assign acc           = |(bus.req_valid & grant);

  // select the byte of the current owner
  always_comb begin
    byte_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) byte_in = bus.req_data[8*i +: 8];
    end
  end

  // next-state, grant, timer and hit bookkeeping
  always_comb begin
    state_n  = state;
    grant_n  = grant;
    owner_n  = owner;
    ptr_n    = ptr;
    timer_n  = timer;
    hit_n    = 1'b0;
    hit_id_n = hit_id;
    cnt_n    = hit_count;
    rel      = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_n = pick;
          owner_n = pick_idx;
          state_n = W0;
          timer_n = '0;
        end
      end
      default: begin
        if (acc) begin
          timer_n = '0;
          if (byte_in == PAT0) begin
            state_n = W1;
          end else if (state == W1 && byte_in == PAT1) begin
            state_n = W2;
          end else if (state == W2 && byte_in == PAT2) begin
            rel      = 1'b1;
            hit_n    = 1'b1;
            hit_id_n = owner;
            if (hit_count != 8'hFF) cnt_n = hit_count + 8'd1;
          end else begin
            rel = 1'b1;
          end
        end else if (timer == 8'(TIMEOUT - 1)) begin
          rel = 1'b1;
        end else begin
          timer_n = timer + 8'd1;
        end
        if (rel) begin
          grant_n = '0;
          state_n = IDLE;
          timer_n = '0;
          ptr_n   = (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;
        end
      end
    endcase
  end

  // state registers with async abort on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= '0;
      ptr       <= '0;
      timer     <= '0;
      hit       <= 1'b0;
      hit_id    <= '0;
      hit_count <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      owner     <= owner_n;
      ptr       <= ptr_n;
      timer     <= timer_n;
      hit       <= hit_n;
      hit_id    <= hit_id_n;
      hit_count <= cnt_n;
    end
  end

endmodule
